// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sharing of one combinational ALU between two requesters
//
// Ports:
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   req_valid[1:0] / req_ready  per-requester request handshake (ready asserted combinationally in IDLE)
//   reqN_op / reqN_a / reqN_b   requester N opcode {mode,opsel} and operands
//   rsp_valid / rsp_ready       response handshake
//   rsp_id / rsp_result         issuing requester and captured ALU result
//   rsp_flags / rsp_err         captured {c,z,o,s} flags, illegal-opcode indication
//   alu_op1/op2/opsel/mode      registered operands and opcode driven to the ALU
//   alu_result, alu_c/z/o/s     combinational ALU outputs
//   busy                        controller is not idle

module alu_share_ctrl #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [3:0]        req0_op,
    input  logic [DWIDTH-1:0] req0_a,
    input  logic [DWIDTH-1:0] req0_b,
    input  logic [3:0]        req1_op,
    input  logic [DWIDTH-1:0] req1_a,
    input  logic [DWIDTH-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DWIDTH-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic [DWIDTH-1:0] alu_op1,
    output logic [DWIDTH-1:0] alu_op2,
    output logic [2:0]        alu_opsel,
    output logic              alu_mode,
    input  logic [DWIDTH-1:0] alu_result,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              alu_o,
    input  logic              alu_s,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic              id_q;
    logic              err_q;
    logic [DWIDTH-1:0] alu_op1_q;
    logic [DWIDTH-1:0] alu_op2_q;
    logic [2:0]        alu_opsel_q;
    logic              alu_mode_q;
    logic              rsp_valid_q;
    logic              rsp_id_q;
    logic [DWIDTH-1:0] rsp_result_q;
    logic [3:0]        rsp_flags_q;
    logic              rsp_err_q;

    logic              accept_d;
    logic              grant_d;
    logic [3:0]        op_d;
    logic [DWIDTH-1:0] a_d;
    logic [DWIDTH-1:0] b_d;
    logic              illegal_d;

    // Grant selection: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        accept_d  = rst_n && (state_q == IDLE) && (req_valid != 2'b00);
        grant_d   = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        op_d      = grant_d ? req1_op : req0_op;
        a_d       = grant_d ? req1_a  : req0_a;
        b_d       = grant_d ? req1_b  : req0_b;
        illegal_d = (op_d == 4'h7) || (op_d == 4'hC) || (op_d == 4'hE) || (op_d == 4'hF);
        req_ready = 2'b00;
        if (accept_d) begin
            req_ready = grant_d ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_opsel_q  <= 3'd0;
            alu_mode_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= 4'd0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        alu_op1_q    <= a_d;
                        alu_op2_q    <= b_d;
                        alu_opsel_q  <= op_d[2:0];
                        alu_mode_q   <= op_d[3];
                        id_q         <= grant_d;
                        err_q        <= illegal_d;
                        last_grant_q <= grant_d;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    // The ALU has had a full cycle on the registered operands; capture it.
                    rsp_valid_q  <= 1'b1;
                    rsp_id_q     <= id_q;
                    rsp_err_q    <= err_q;
                    rsp_result_q <= err_q ? '0 : alu_result;
                    rsp_flags_q  <= err_q ? 4'd0 : {alu_c, alu_z, alu_o, alu_s};
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign alu_opsel  = alu_opsel_q;
    assign alu_mode   = alu_mode_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed bench for alu_share_ctrl with a stand-in ALU
module tb_alu_share_ctrl;

    localparam int DWIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [3:0]        req0_op;
    logic [DWIDTH-1:0] req0_a;
    logic [DWIDTH-1:0] req0_b;
    logic [3:0]        req1_op;
    logic [DWIDTH-1:0] req1_a;
    logic [DWIDTH-1:0] req1_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DWIDTH-1:0] rsp_result;
    logic [3:0]        rsp_flags;
    logic              rsp_err;
    logic [DWIDTH-1:0] alu_op1;
    logic [DWIDTH-1:0] alu_op2;
    logic [2:0]        alu_opsel;
    logic              alu_mode;
    logic [DWIDTH-1:0] alu_result;
    logic              alu_c;
    logic              alu_z;
    logic              alu_o;
    logic              alu_s;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.DWIDTH(DWIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .rsp_err    (rsp_err),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_opsel  (alu_opsel),
        .alu_mode   (alu_mode),
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .alu_z      (alu_z),
        .alu_o      (alu_o),
        .alu_s      (alu_s),
        .busy       (busy)
    );

    // Stand-in ALU covering add/and/xor; anything else returns garbage so that
    // an illegal opcode that leaks through is visible.
    logic [DWIDTH:0] sum;
    always_comb begin
        sum        = {1'b0, alu_op1} + {1'b0, alu_op2};
        alu_result = 32'hDEADBEEF;
        alu_c      = 1'b1;
        alu_o      = 1'b1;
        case ({alu_mode, alu_opsel})
            4'h0: begin
                alu_result = sum[DWIDTH-1:0];
                alu_c      = sum[DWIDTH];
                alu_o      = (alu_op1[DWIDTH-1] == alu_op2[DWIDTH-1]) &&
                             (sum[DWIDTH-1] != alu_op1[DWIDTH-1]);
            end
            4'h8: begin
                alu_result = alu_op1 & alu_op2;
                alu_c      = 1'b0;
                alu_o      = 1'b0;
            end
            4'hA: begin
                alu_result = alu_op1 ^ alu_op2;
                alu_c      = 1'b0;
                alu_o      = 1'b0;
            end
            default: ;
        endcase
        alu_z = (alu_result == '0);
        alu_s = alu_result[DWIDTH-1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, rsp_valid, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req0_op = 4'h0; req0_a = '0; req0_b = '0;
        req1_op = 4'h0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;

        // Reset state; req_ready held low while in reset even with a request pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 2'b01;
        #1;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_op1", alu_op1, 0);
        chk("rst_rsp_result", rsp_result, 0);
        req_valid = 2'b00;
        rst_n     = 1'b1;

        // Requester 0: 5 + 7.
        @(negedge clk);
        req_valid = 2'b01; req0_op = 4'h0; req0_a = 32'd5; req0_b = 32'd7; rsp_ready = 1'b1;
        #1;
        chk("t1_req_ready", req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        req0_a    = 32'd99;
        chk("t1_exec_busy", busy, 1);
        chk("t1_exec_no_rsp", rsp_valid, 0);
        chk("t1_alu_op1", alu_op1, 5);
        chk("t1_alu_op2", alu_op2, 7);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_result", rsp_result, 12);
        chk("t1_flags", rsp_flags, 4'b0000);
        chk("t1_id", rsp_id, 0);
        chk("t1_err", rsp_err, 0);
        chk("t1_resp_busy", busy, 1);
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_rsp", rsp_valid, 0);

        // Requester 1: FFFFFFFF + 1 -> 0 with carry and zero.
        req_valid = 2'b10; req1_op = 4'h0; req1_a = 32'hFFFFFFFF; req1_b = 32'd1;
        #1;
        chk("t2_req_ready", req_ready, 2'b10);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp("t2_rsp_timeout");
        chk("t2_result", rsp_result, 0);
        chk("t2_flags", rsp_flags, 4'b1100);
        chk("t2_id", rsp_id, 1);
        @(negedge clk);

        // Both requesters continuously valid: strict alternation starting at 0.
        req0_op = 4'h8; req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00;
        req1_op = 4'hA; req1_a = 32'hF0F0F0F0; req1_b = 32'hFF00FF00;
        req_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            wait_rsp("t3_rsp_timeout");
            chk("t3_id", rsp_id, i % 2);
            chk("t3_result", rsp_result, (i % 2 == 0) ? 32'hF000F000 : 32'h0FF00FF0);
            chk("t3_resp_ready_low", req_ready, 2'b00);
            @(negedge clk);
        end
        req_valid = 2'b00;
        @(negedge clk);

        // Backpressure: response and ALU drive frozen, no accepts.
        rsp_ready = 1'b0;
        req_valid = 2'b01; req0_op = 4'h0; req0_a = 32'd3; req0_b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        wait_rsp("t4_rsp_timeout");
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_result", rsp_result, 7);
            chk("t4_hold_id", rsp_id, 0);
            chk("t4_hold_alu_op1", alu_op1, 3);
            chk("t4_hold_ready", req_ready, 2'b00);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("t4_release_busy", busy, 0);
        chk("t4_release_rsp", rsp_valid, 0);

        // Illegal opcode 7, then a normal add.
        req_valid = 2'b01; req0_op = 4'h7; req0_a = 32'd1; req0_b = 32'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp("t5_rsp_timeout");
        chk("t5_err", rsp_err, 1);
        chk("t5_result", rsp_result, 0);
        chk("t5_flags", rsp_flags, 0);
        @(negedge clk);
        req_valid = 2'b01; req0_op = 4'h0; req0_a = 32'd10; req0_b = 32'd20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp("t5b_rsp_timeout");
        chk("t5b_err", rsp_err, 0);
        chk("t5b_result", rsp_result, 30);
        @(negedge clk);

        // Reset while in EXEC: operation dropped, tie priority restored to requester 0.
        req_valid = 2'b01; req0_op = 4'h0; req0_a = 32'd9; req0_b = 32'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_alu_op1", alu_op1, 0);
        chk("t6_rst_result", rsp_result, 0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_no_rsp", rsp_valid, 0);
        req_valid = 2'b11;
        #1;
        chk("t6_tie_ready", req_ready, 2'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp("t6_rsp_timeout");
        chk("t6_tie_id", rsp_id, 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Two-requester arbiter/sequencer that shares one alu_128bit instance (32-bit datapath) between independent clients.
- Accepts requests {opcode, a, b} through per-requester valid/ready handshakes and grants round-robin.
- Drives the ALU from registered operands and returns result, flags and requester ID through a single response handshake.
- Sits between the decode/issue logic and the ALU.

Parameters:
- DWIDTH, 32, operand/result width; must match the ALU's DWIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  2  bit i = requester i presents a request
- req_ready  out  2  bit i = request from i accepted this cycle
- req0_op  in  4  requester 0 opcode {mode,opsel}
- req0_a, req0_b  in  DWIDTH  requester 0 operands
- req1_op  in  4  requester 1 opcode
- req1_a, req1_b  in  DWIDTH  requester 1 operands
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the response
- rsp_result  out  DWIDTH  captured ALU result
- rsp_flags  out  4  {c,z,o,s} captured ALU flags
- rsp_err  out  1  illegal opcode
- alu_op1, alu_op2  out  DWIDTH  to ALU op1/op2
- alu_opsel  out  3  to ALU opsel
- alu_mode  out  1  to ALU mode
- alu_result  in  DWIDTH  from ALU result
- alu_c, alu_z, alu_o, alu_s  in  1  from ALU flags
- busy  out  1  state != IDLE

Behaviour:
- Legal opcodes: 0 add, 1 subwb, 2 mov, 3 sub, 4 inc, 5 dec, 6 addinc, 8 and, 9 or, A xor, B not, D shl. Illegal: 7, C, E, F.
- FSM states: IDLE, EXEC, RESP.
- IDLE -> EXEC on any accept. EXEC -> RESP unconditionally. RESP -> IDLE on rsp_valid & rsp_ready.
- Arbitration, IDLE only:
  - grant = the single valid requester; if both are valid, the requester != last_grant.
  - req_ready[grant] = 1 combinationally. req_ready = 2'b00 in EXEC and RESP, and whenever no request is valid.
  - last_grant updates to grant on accept.
- On accept at edge k: register opcode, a, b and ID.
  - alu_op1 = a, alu_op2 = b, alu_opsel = op[2:0], alu_mode = op[3], all driven from registers during cycle k..k+1.
  - ALU is combinational; its outputs are sampled at edge k+1 into the rsp_* registers.
  - rsp_valid = 1 from edge k+1.
  - Minimum spacing is 3 cycles per operation; the response is held stable until accepted.
- Illegal opcode: still passes through EXEC, but the capture forces rsp_err = 1, rsp_result = 0, rsp_flags = 0. The ALU operands are driven with the raw values (don't care).
- rsp_err = 0 for legal opcodes.
- Backpressure: in RESP with rsp_ready = 0, all rsp_* outputs and alu_* outputs stay constant, req_ready = 0, and no new request is accepted.
- A response accepted in RESP returns to IDLE. A new request can be accepted in the following cycle, not the same cycle.
- Reset values (rst_n low at a rising edge):
  - state = IDLE, last_grant = 1 (so requester 0 wins the first tie).
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_flags = 0, rsp_err = 0.
  - alu_op1 = 0, alu_op2 = 0, alu_opsel = 0, alu_mode = 0, busy = 0.
  - req_ready = 0 while rst_n is low.
- Reset mid-operation (EXEC or RESP): the pending operation is discarded, with no response.
- Requester inputs are sampled only at accept; changes afterwards have no effect.

Test Plan:
- Requester 0 sends op 0 (add), a = 5, b = 7, rsp_ready = 1 -> req_ready = 01 at the accept edge; rsp_valid rises 1 edge later with rsp_result = 12, flags = 0000, rsp_id = 0, rsp_err = 0; busy is high for 2 cycles.
- Requester 1 sends op 0 with a = 32'hFFFFFFFF, b = 1 -> rsp_result = 0, c = 1, z = 1, rsp_id = 1.
- Both requesters valid continuously (req0: op 8, a = F0F0F0F0, b = FF00FF00; req1: op A, same operands), 6 operations -> grant order 0,1,0,1,0,1; results 0xF000F000 and 0x0FF00FF0 respectively.
- rsp_ready held low for 5 cycles after rsp_valid -> rsp_* and alu_* are stable, req_ready = 00 throughout, no second accept; the accept then returns to IDLE.
- Opcode 4'h7 from requester 0 -> rsp_err = 1, rsp_result = 0, rsp_flags = 0; the next legal request completes normally.
- rst_n driven low for 1 cycle while in EXEC -> no rsp_valid, busy = 0, all outputs zero; the next tie is granted to requester 0.
